fetch_sequencer: RTL
====================

# fetch_sequencer

- Sequences instruction fetch for the non-pipelined LEGv8 core.
- Owns the program counter and drives a handshaked instruction-memory request port with variable latency.
- Holds each fetched instruction stable for the decode/execute datapath until it is consumed, then advances to PC+4 or a taken branch target.
- Sits between the core datapath and the instruction memory.

## Interface

Parameters:
- RESET_PC, `WORD'd0: address of the first fetch after start.
- TIMEOUT, 16: maximum WAIT cycles before a fetch fault (only with FETCH_TIMEOUT_EN).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  leave IDLE and begin fetching at RESET_PC.
- stall  input  1  datapath not ready; held instruction must not be consumed.
- pc_src  input  1  the held instruction's branch is taken; sampled on consume.
- branch_target  input  `WORD  next PC when pc_src=1.
- halt_req  input  1  stop fetching; sampled in IDLE and on consume.
- mem_req  output  1  instruction-memory request.
- mem_addr  output  `WORD  request address; stable while mem_req=1.
- mem_ready  input  1  memory response valid this cycle.
- mem_rdata  input  `INSTR_LEN  instruction word; valid with mem_ready.
- instruction  output  `INSTR_LEN  held instruction.
- instr_valid  output  1  instruction/pc valid.
- pc  output  `WORD  address of held instruction.
- halted  output  1  sequencer in HALT.
- fetch_fault  output  1  fetch timed out (sticky until reset).

## Operation

States: IDLE, REQ, WAIT, HOLD, HALT.

- **IDLE**
  - mem_req=0.
  - halt_req=1 -> HALT (halt_req takes priority over start).
  - else start=1 -> REQ with fetch_pc=RESET_PC.
- **REQ**
  - mem_req=1, mem_addr=fetch_pc.
  - mem_ready=1 -> capture mem_rdata into instruction and fetch_pc into pc, go to HOLD.
  - otherwise -> WAIT.
- **WAIT**
  - mem_req=1, same address.
  - Go to HOLD with capture when mem_ready=1.
- **HOLD**
  - instr_valid=1; instruction and pc stable.
  - stall=1 -> remain in HOLD.
  - stall=0 -> consume:
    - next fetch_pc = pc_src ? {branch_target[`WORD-1:2], 2'b00} : pc + 4.
    - halt_req=1 -> HALT; else -> REQ.
- **HALT**
  - mem_req=0, instr_valid=0, halted=1.
  - Exit only by reset.
- mem_ready is ignored outside REQ/WAIT.
- Arithmetic:
  - pc + 4 is `WORD wide and wraps modulo 2^`WORD (max address -> 0).
  - Branch targets have bits [1:0] forced to 0; no fault is raised for them.

## Timing

Reset values (asynchronous, on reset=0):
- state=IDLE.
- mem_req=0, mem_addr=RESET_PC.
- instruction=0, pc=RESET_PC, instr_valid=0.
- halted=0, fetch_fault=0.

Reset mid-operation:
- Outputs return to reset values immediately.
- An outstanding request is abandoned; mem_req drops without waiting for mem_ready.

Latency and throughput:
- start sampled at edge N -> mem_req=1 during cycle N+1.
- mem_ready in the cycle of request edge M -> instr_valid=1 after edge M.
- Zero-wait memory: one instruction every 2 cycles (REQ, HOLD) with stall=0.
- instr_valid falls on the edge where stall=0 is sampled in HOLD.

Simultaneous events:
- stall=0 with halt_req=1 and pc_src=1 in HOLD -> HALT; the branch target is discarded.
- start and halt_req together in IDLE -> HALT.

## Configuration

FETCH_TIMEOUT_EN:
- **Defined**
  - A counter clears on entering REQ and increments each WAIT cycle without mem_ready.
  - At TIMEOUT consecutive WAIT cycles, the state moves to HALT on that edge.
  - On that transition fetch_fault=1, mem_req=0, halted=1.
- **Undefined**
  - WAIT persists indefinitely.
  - fetch_fault is tied 0 and TIMEOUT is unused.
  - Port list is unchanged.

## Test plan

- **Basic fetch:** reset, start=1 one cycle, memory zero-wait, stall=0, pc_src=0 -> mem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses every 2nd cycle with matching pc.
- **Stall and wait states:** mem_ready delayed 3 cycles, then stall=1 for 4 cycles in HOLD -> mem_addr stable for 4 request cycles; instruction/pc unchanged through the stall; next request only after stall=0.
- **Branch:** at pc=0x8 with pc_src=1, branch_target=0x103 on consume -> next mem_addr=0x100.
- **Wrap:** pc=0xFFFF_FFFF_FFFF_FFFC consumed with pc_src=0 -> next mem_addr=0x0.
- **Halt:** halt_req=1 with stall=0 in HOLD -> halted=1, mem_req=0 next cycle. Reset asserted during WAIT -> mem_req=0 and pc=RESET_PC immediately, before the clock edge.
- **Timeout (FETCH_TIMEOUT_EN, TIMEOUT=16):** mem_ready held 0 -> fetch_fault=1, halted=1 after 16 WAIT cycles. Without the macro -> still in WAIT after 100 cycles with fetch_fault=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer for the non-pipelined LEGv8 core: owns the PC and handshakes with
// variable-latency instruction memory. Define FETCH_TIMEOUT_EN to enable the WAIT timeout fault.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module fetch_sequencer #(
   parameter logic [`WORD-1:0] RESET_PC = `WORD'd0,
   parameter int unsigned      TIMEOUT  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stall,
   input  logic                  pc_src,
   input  logic [`WORD-1:0]      branch_target,
   input  logic                  halt_req,
   output logic                  mem_req,
   output logic [`WORD-1:0]      mem_addr,
   input  logic                  mem_ready,
   input  logic [`INSTR_LEN-1:0] mem_rdata,
   output logic [`INSTR_LEN-1:0] instruction,
   output logic                  instr_valid,
   output logic [`WORD-1:0]      pc,
   output logic                  halted,
   output logic                  fetch_fault
);

   localparam int unsigned WORD_W  = `WORD;
   localparam int unsigned INSTR_W = `INSTR_LEN;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

   state_t              state, state_n;
   logic                mem_req_n, instr_valid_n, halted_n, fetch_fault_n;
   logic [WORD_W-1:0]   mem_addr_n, pc_n, next_pc;
   logic [INSTR_W-1:0]  instruction_n;

   if (TIMEOUT == 0) begin : g_timeout_check
      $error("fetch_sequencer: TIMEOUT must be nonzero");
   end

   // Successor of the held instruction; branch targets are forced word-aligned.
   assign next_pc = pc_src ? (branch_target & ~WORD_W'(3)) : pc + WORD_W'(4);

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_c;

   // Counts consecutive WAIT cycles without a response; zero everywhere else.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wait_cnt <= '0;
      else if (state == S_WAIT && !mem_ready)
         wait_cnt <= wait_cnt + CNT_W'(1);
      else
         wait_cnt <= '0;
   end

   assign timeout_c = (32'(wait_cnt) + 32'd1) == TIMEOUT;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         mem_req     <= 1'b0;
         mem_addr    <= RESET_PC;
         instruction <= '0;
         pc          <= RESET_PC;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         state       <= state_n;
         mem_req     <= mem_req_n;
         mem_addr    <= mem_addr_n;
         instruction <= instruction_n;
         pc          <= pc_n;
         instr_valid <= instr_valid_n;
         halted      <= halted_n;
         fetch_fault <= fetch_fault_n;
      end
   end

   // Next state plus next values of the registered outputs.
   always_comb begin
      state_n       = state;
      mem_req_n     = mem_req;
      mem_addr_n    = mem_addr;
      instruction_n = instruction;
      pc_n          = pc;
      instr_valid_n = instr_valid;
      halted_n      = halted;
      fetch_fault_n = fetch_fault;
      case (state)
         S_IDLE: begin
            if (halt_req) begin
               state_n  = S_HALT;
               halted_n = 1'b1;
            end else if (start) begin
               state_n    = S_REQ;
               mem_req_n  = 1'b1;
               mem_addr_n = RESET_PC;
            end
         end
         S_REQ, S_WAIT: begin
            if (mem_ready) begin
               state_n       = S_HOLD;
               mem_req_n     = 1'b0;
               instruction_n = mem_rdata;
               pc_n          = mem_addr;
               instr_valid_n = 1'b1;
            end else begin
               state_n = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
               if (state == S_WAIT && timeout_c) begin
                  state_n       = S_HALT;
                  mem_req_n     = 1'b0;
                  halted_n      = 1'b1;
                  fetch_fault_n = 1'b1;
               end
`endif
            end
         end
         S_HOLD: begin
            if (!stall) begin
               instr_valid_n = 1'b0;
               if (halt_req) begin
                  state_n  = S_HALT;
                  halted_n = 1'b1;
               end else begin
                  state_n    = S_REQ;
                  mem_req_n  = 1'b1;
                  mem_addr_n = next_pc;
               end
            end
         end
         S_HALT: ;
         default: state_n = S_IDLE;
      endcase
   end

endmodule
